// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared pointer helpers for the dual-clock FIFO. The write-side and read-side
// control blocks both import this package, so they use the same Gray encoding
// and the same pointer-width rules.
//   ptr_width(aw)  : pointer width for a RAM address width aw (one extra wrap bit)
//   fifo_depth(aw) : number of words for a RAM address width aw
//   bin2gray / gray2bin : conversions on a GRAY_MAX_W-bit word. Callers
//                         zero-extend narrower pointers into the word and take
//                         the low bits of the result.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic int unsigned ptr_width(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR by doubling shifts: each binary bit becomes the XOR of
    // every Gray bit at or above it.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        for (int unsigned s = 1; s < GRAY_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_gray_ptr.sv
// -----------------------------------------------------------------------------
// async_fifo_gray_ptr
// Binary/Gray pointer register with an increment enable. The register holds
// both the binary count and its Gray image. It also exposes the Gray value the
// pointer will take after this edge, so a full or empty test can be applied to
// the next pointer. The read side reuses this block.
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (pointer -> 0)
//   i_inc        advance the pointer by one on this edge
//   o_bin        registered binary pointer
//   o_gray       registered Gray pointer
//   o_gray_next  Gray image of (o_bin + i_inc), combinational
// -----------------------------------------------------------------------------
module async_fifo_gray_ptr
    import async_fifo_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_bin,
    output logic [W-1:0] o_gray,
    output logic [W-1:0] o_gray_next
);

    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic [W-1:0] w_bin_next;
    gray_word_t   w_gray_word;
    logic         w_unused_hi;

    assign w_bin_next  = r_bin + {{(W-1){1'b0}}, i_inc};
    assign w_gray_word = bin2gray(gray_word_t'(w_bin_next));
    assign o_gray_next = w_gray_word[W-1:0];
    // Bits above W are zero because the input was zero-extended.
    assign w_unused_hi = ^w_gray_word[GRAY_MAX_W-1:W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= o_gray_next;
        end
    end

    assign o_bin  = r_bin;
    assign o_gray = r_gray;

endmodule

// File: rtl/async_fifo_wr_task_logic.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_task_logic
// Write-side control for the dual-clock FIFO. Everything runs in the write
// clock domain.
// Optional feature macro: ASYNC_FIFO_WR_OVERFLOW_EN adds the wr_overflow output.
// Ports:
//   wrclk        write clock
//   reset_n      asynchronous active-low reset
//   wrreq        write request
//   wrq2_rdptr   Gray read pointer, already two-stage synchronized into wrclk
//   wren         RAM write enable (wrreq & ~wrfull)
//   wraddr       RAM write address (low bits of the registered binary pointer)
//   wrptr        registered Gray write pointer, sent to the read domain
//   wrfull       registered full flag
//   prog_full    registered, used words >= PROG_FULL_THR
//   wrusedw      registered used-word count modulo depth (0 when exactly full)
//   wr_overflow  (macro only) one-cycle pulse per request dropped while full
// -----------------------------------------------------------------------------
module async_fifo_wr_task_logic
    import async_fifo_pkg::*;
#(
    parameter int unsigned FIFO_ADDR_WIDTH = 8,
    parameter int unsigned PROG_FULL_THR   = 192
) (
    input  logic                       wrclk,
    input  logic                       reset_n,
    input  logic                       wrreq,
    input  logic [FIFO_ADDR_WIDTH:0]   wrq2_rdptr,
    output logic                       wren,
    output logic [FIFO_ADDR_WIDTH-1:0] wraddr,
    output logic [FIFO_ADDR_WIDTH:0]   wrptr,
    output logic                       wrfull,
    output logic                       prog_full,
    output logic [FIFO_ADDR_WIDTH-1:0] wrusedw
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
    ,
    output logic                       wr_overflow
`endif
);

    localparam int unsigned AW = FIFO_ADDR_WIDTH;
    localparam int unsigned PW = ptr_width(AW);

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_gray;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_full_pattern;
    logic [PW-1:0] w_used;
    gray_word_t    w_rdbin_word;
    logic          w_unused_hi;
    logic          w_wren;

    logic [PW-1:0] r_rdbin;
    logic          r_full;
    logic          r_prog_full;
    logic [AW-1:0] r_usedw;

    assign w_wren = wrreq & ~r_full;

    async_fifo_gray_ptr #(
        .W (PW)
    ) u_wr_ptr (
        .i_clk       (wrclk),
        .i_rst_n     (reset_n),
        .i_inc       (w_wren),
        .o_bin       (w_bin),
        .o_gray      (w_gray),
        .o_gray_next (w_gray_next)
    );

    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer. In Gray code, that is the top two bits inverted and the rest equal.
    assign w_full_pattern = {~wrq2_rdptr[AW:AW-1], wrq2_rdptr[AW-2:0]};

    assign w_rdbin_word = gray2bin(gray_word_t'(wrq2_rdptr));
    // Bits above PW are zero because the input was zero-extended.
    assign w_unused_hi  = ^w_rdbin_word[GRAY_MAX_W-1:PW];

    // Modulo 2**PW subtraction stays correct across pointer wrap.
    assign w_used = w_bin - r_rdbin;

    always_ff @(posedge wrclk or negedge reset_n) begin
        if (!reset_n) begin
            r_full      <= 1'b0;
            r_rdbin     <= '0;
            r_usedw     <= '0;
            r_prog_full <= 1'b0;
        end else begin
            r_full      <= (w_gray_next == w_full_pattern);
            r_rdbin     <= w_rdbin_word[PW-1:0];
            r_usedw     <= w_used[AW-1:0];
            r_prog_full <= (w_used >= PW'(PROG_FULL_THR));
        end
    end

`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge wrclk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wrreq & r_full;
        end
    end

    assign wr_overflow = r_overflow;
`endif

    assign wren      = w_wren;
    assign wraddr    = w_bin[AW-1:0];
    assign wrptr     = w_gray;
    assign wrfull    = r_full;
    assign prog_full = r_prog_full;
    assign wrusedw   = r_usedw;

endmodule

// File: tb/tb_async_fifo_wr_task_logic.sv
module tb_async_fifo_wr_task_logic;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned THR   = 12;

    logic       wrclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wrreq = 1'b0;
    logic [4:0] wrq2_rdptr = '0;
    logic       wren;
    logic [3:0] wraddr;
    logic [4:0] wrptr;
    logic       wrfull;
    logic       prog_full;
    logic [3:0] wrusedw;
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
    logic       wr_overflow;
`endif

    async_fifo_wr_task_logic #(
        .FIFO_ADDR_WIDTH (4),
        .PROG_FULL_THR   (12)
    ) dut (
        .wrclk      (wrclk),
        .reset_n    (reset_n),
        .wrreq      (wrreq),
        .wrq2_rdptr (wrq2_rdptr),
        .wren       (wren),
        .wraddr     (wraddr),
        .wrptr      (wrptr),
        .wrfull     (wrfull),
        .prog_full  (prog_full),
        .wrusedw    (wrusedw)
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
        ,
        .wr_overflow (wr_overflow)
`endif
    );

    always #5 wrclk = ~wrclk;

    typedef struct packed {
        logic       wren;
        logic [3:0] wraddr;
        logic [4:0] wrptr;
        logic       wrfull;
        logic       prog_full;
        logic [3:0] wrusedw;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: whole-transaction counts.
    //   m_w     writes accepted before the current cycle
    //   m_wp    the same count one cycle earlier
    //   m_rd    read count presented in the current cycle
    //   m_rdp   read count from the previous cycle
    //   m_rdpp  read count from two cycles earlier
    int unsigned m_w, m_wp, m_rd, m_rdp, m_rdpp;
    bit          m_req_prev, m_full_prev;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    function automatic logic [4:0] gray5(input int unsigned b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    // One write-clock cycle: drive inputs just after the edge, then queue what
    // the outputs must show during this cycle.
    task automatic cycle(input bit req, input bit rst, input int unsigned rd);
        exp_t        e;
        int unsigned used;
        bit          full;
        @(posedge wrclk);
        #1;
        wrreq = req;
        if (rst) begin
            reset_n     = 1'b0;
            wrq2_rdptr  = '0;
            m_w = 0; m_wp = 0; m_rd = 0; m_rdp = 0; m_rdpp = 0;
            m_req_prev  = 1'b0;
            m_full_prev = 1'b0;
            e      = '0;
            e.wren = req;
            exp_q.push_back(e);
        end else begin
            reset_n    = 1'b1;
            m_rd       = rd;
            wrq2_rdptr = gray5(rd);
            full        = ((m_w - m_rdp) == DEPTH);
            used        = (m_wp - m_rdpp) % (2 * DEPTH);
            e.wren      = req & ~full;
            e.wraddr    = 4'(m_w % DEPTH);
            e.wrptr     = gray5(m_w);
            e.wrfull    = full;
            e.prog_full = (used >= THR);
            e.wrusedw   = 4'(used % DEPTH);
            e.ov        = m_req_prev & m_full_prev;
            exp_q.push_back(e);
            m_rdpp      = m_rdp;
            m_rdp       = rd;
            m_wp        = m_w;
            if (e.wren) m_w = m_w + 1;
            m_req_prev  = req;
            m_full_prev = full;
        end
    endtask

    task automatic peek();
        @(negedge wrclk);
        #1;
    endtask

    // Monitor: pops one expectation per cycle and compares at mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge wrclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wren",      int'(wren),      int'(e.wren));
                chk("wraddr",    int'(wraddr),    int'(e.wraddr));
                chk("wrptr",     int'(wrptr),     int'(e.wrptr));
                chk("wrfull",    int'(wrfull),    int'(e.wrfull));
                chk("prog_full", int'(prog_full), int'(e.prog_full));
                chk("wrusedw",   int'(wrusedw),   int'(e.wrusedw));
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
                chk("wr_overflow", int'(wr_overflow), int'(e.ov));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rd;
        bit          req;

        // Reset held with wrreq=1.
        repeat (2) cycle(1'b1, 1'b1, 0);
        cycle(1'b1, 1'b1, 0);
        peek();
        chk("rst_wrptr",   int'(wrptr),   0);
        chk("rst_wrfull",  int'(wrfull),  0);
        chk("rst_wrusedw", int'(wrusedw), 0);
        chk("rst_wren",    int'(wren),    1);

        // Fill with the read pointer parked at 0: 17 requests.
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, 0);
            peek();
            if (i < 16) begin
                chk("fill_wraddr", int'(wraddr), i);
                chk("fill_wren",   int'(wren),   1);
            end else begin
                chk("fill_17_wren", int'(wren), 0);
            end
        end

        // Two more requests while full: dropped, pointer holds.
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        peek();
        chk("full_wrptr",     int'(wrptr),     5'b11000);
        chk("full_wrfull",    int'(wrfull),    1);
        chk("full_wrusedw",   int'(wrusedw),   0);
        chk("full_prog_full", int'(prog_full), 1);
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
        chk("ovf_pulse", int'(wr_overflow), 1);
`endif

        // Read pointer jumps to 4.
        cycle(1'b0, 1'b0, 4);
        peek();
        chk("free_wrfull_same", int'(wrfull), 1);
        cycle(1'b0, 1'b0, 4);
        peek();
        chk("free_wrfull_next", int'(wrfull), 0);
        cycle(1'b0, 1'b0, 4);
        peek();
        chk("free_wrusedw",   int'(wrusedw),   12);
        chk("free_prog_full", int'(prog_full), 1);

        // Read pointer advances to 5: 11 used words, below threshold.
        repeat (3) cycle(1'b0, 1'b0, 5);
        peek();
        chk("thr_prog_full", int'(prog_full), 0);
        chk("thr_wrusedw",   int'(wrusedw),   11);

        // Randomized traffic. Slow reads first, so the FIFO fills often.
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 99) < 75);
            if (i < 200) rd = m_rd + (($urandom_range(0, 3) == 0) ? 1 : 0);
            else         rd = m_rd + $urandom_range(0, 2);
            if (rd > m_w) rd = m_w;
            if (i == 150) begin
                cycle(req, 1'b1, 0);
                peek();
                chk("midrst_wrptr",  int'(wrptr),  0);
                chk("midrst_wrfull", int'(wrfull), 0);
                cycle(1'b0, 1'b1, 0);
            end else begin
                cycle(req, 1'b0, rd);
            end
        end

        // Wrap: continuous writes with the read pointer trailing the next
        // write pointer by 3, across the 31 -> 0 pointer wrap.
        repeat (2) cycle(1'b0, 1'b1, 0);
        for (int i = 0; i < 44; i++) begin
            rd = (m_w >= 2) ? m_w - 2 : 0;
            cycle(1'b1, 1'b0, rd);
            peek();
            if (i >= 4) begin
                chk("wrap_wrusedw", int'(wrusedw), 3);
                chk("wrap_wrfull",  int'(wrfull),  0);
            end
        end

        repeat (2) @(negedge wrclk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
